// File: rtl/pipe_buf.sv
// pipe_buf: inter-stage pipeline record buffer.
// Circular FIFO of DEPTH records between two pipeline stages. Both sides use
// four-phase handshakes and pipe_buf is the responder on each side.
// Optional feature macro: PIPE_BUF_FLUSH_EN adds a `flush` input that
// discards every queued record (e.g. on a resolved jump or branch).
//
// Handshake semantics (both sides): the requester raises its request (we/re)
// and holds it, with din stable on the write side, until it sees the
// acknowledge. The acknowledge (wack/rack) rises in the cycle after the
// request is accepted and stays high until the request is seen low. A new
// request is considered only once the FSM is back in IDLE. Full and empty are
// judged on the registered count only.
module pipe_buf #(
  parameter int DW    = 128,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] din,
  output logic          wack,
  output logic          avail,
  input  logic          re,
  output logic          rack,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count
`ifdef PIPE_BUF_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  typedef enum logic { W_IDLE = 1'b0, W_ACK = 1'b1 } w_state_t;
  typedef enum logic { R_IDLE = 1'b0, R_ACK = 1'b1 } r_state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // FSM state is kept in plainly named signals so checkers can bind to them.
  w_state_t      w_state;
  r_state_t      r_state;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  logic          do_flush;
  logic          wr_acc;
  logic          rd_acc;
  logic [AW:0]   count_nx;

`ifdef PIPE_BUF_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Acceptance is judged on the registered count, and a flush cancels
  // whatever write or read would otherwise be accepted in that cycle.
  always_comb begin
    wr_acc   = (w_state == W_IDLE) && we && (count != FULL_COUNT) && !do_flush;
    rd_acc   = (r_state == R_IDLE) && re && (count != '0) && !do_flush;
    count_nx = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
  end

  // Write-side handshake FSM: ack an accepted write, release when we falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      wack    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_acc) begin
            wack    <= 1'b1;
            w_state <= W_ACK;
          end
        end
        W_ACK: begin
          if (!we) begin
            wack    <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: begin
          wack    <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Read-side handshake FSM: ack an accepted read, release when re falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rack    <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_acc) begin
            rack    <= 1'b1;
            r_state <= R_ACK;
          end
        end
        R_ACK: begin
          if (!re) begin
            rack    <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: begin
          rack    <= 1'b0;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // Pointers, occupancy and the registered non-empty flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      avail <= 1'b0;
    end else if (do_flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      avail <= 1'b0;
    end else begin
      if (wr_acc) wp <= wp + AW'(1);
      if (rd_acc) rp <= rp + AW'(1);
      count <= count_nx;
      avail <= (count_nx != '0);
    end
  end

  // Output record register: holds until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_acc) begin
      dout <= mem[rp];
    end
  end

  // Record storage: deliberately not reset, only written on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp] <= din;
  end

endmodule

// File: tb/tb_pipe_buf.sv
// tb_pipe_buf: directed bench for pipe_buf (DW=128, DEPTH=2).
// Inputs are driven on the falling edge and outputs sampled there too.
module tb_pipe_buf;

  localparam int DW    = 128;
  localparam int DEPTH = 2;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          we;
  logic [DW-1:0] din;
  logic          wack;
  logic          avail;
  logic          re;
  logic          rack;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
`ifdef PIPE_BUF_FLUSH_EN
  logic          flush;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];

  pipe_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .din   (din),
    .wack  (wack),
    .avail (avail),
    .re    (re),
    .rack  (rack),
    .dout  (dout),
    .count (count)
`ifdef PIPE_BUF_FLUSH_EN
    ,
    .flush (flush)
`endif
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: full write handshake, bounded wait for wack.
  task automatic write_rec(input logic [DW-1:0] d);
    int waited;
    @(negedge clk);
    we  = 1'b1;
    din = d;
    waited = 0;
    @(negedge clk);
    while (!wack && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("write_wack_seen", {127'b0, wack}, 128'd1);
    we = 1'b0;
    @(negedge clk);
    chk("write_wack_release", {127'b0, wack}, 128'd0);
  endtask

  // Driver: full read handshake, checks the record against the queue head.
  task automatic read_rec();
    int waited;
    logic [DW-1:0] exp;
    @(negedge clk);
    re = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!rack && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("read_rack_seen", {127'b0, rack}, 128'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("read_dout", dout, exp);
    re = 1'b0;
    @(negedge clk);
    chk("read_rack_release", {127'b0, rack}, 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    din = '0;
`ifdef PIPE_BUF_FLUSH_EN
    flush = 1'b0;
`endif
    // Reset state.
    #12;
    chk("rst_wack",  {127'b0, wack},  128'd0);
    chk("rst_rack",  {127'b0, rack},  128'd0);
    chk("rst_avail", {127'b0, avail}, 128'd0);
    chk("rst_count", {126'b0, count}, 128'd0);
    chk("rst_dout",  dout,            128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single transfer of 0x1234.
    @(negedge clk);
    we  = 1'b1;
    din = 128'h1234;
    @(negedge clk);
    chk("single_wack",  {127'b0, wack},  128'd1);
    chk("single_count", {126'b0, count}, 128'd1);
    chk("single_avail", {127'b0, avail}, 128'd1);
    we = 1'b0;
    @(negedge clk);
    chk("single_wack_low", {127'b0, wack}, 128'd0);
    re = 1'b1;
    @(negedge clk);
    chk("single_rack",    {127'b0, rack},  128'd1);
    chk("single_dout",    dout,            128'h1234);
    chk("single_count0",  {126'b0, count}, 128'd0);
    chk("single_avail0",  {127'b0, avail}, 128'd0);
    re = 1'b0;
    @(negedge clk);
    chk("single_rack_low", {127'b0, rack}, 128'd0);
    chk("single_dout_hold", dout, 128'h1234);

    // Full stall: A, B fill the buffer, C must wait for a freed slot.
    write_rec(128'hA);
    exp_q.push_back(128'hA);
    write_rec(128'hB);
    exp_q.push_back(128'hB);
    @(negedge clk);
    we  = 1'b1;
    din = 128'hC;
    repeat (3) @(negedge clk);
    chk("full_wack_stalled", {127'b0, wack},  128'd0);
    chk("full_count",        {126'b0, count}, 128'd2);
    re = 1'b1;
    @(negedge clk);
    chk("full_read_rack",    {127'b0, rack},  128'd1);
    chk("full_read_dout",    dout,            128'hA);
    chk("full_count_freed",  {126'b0, count}, 128'd1);
    chk("full_no_same_cyc",  {127'b0, wack},  128'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("full_c_acked",      {127'b0, wack},  128'd1);
    chk("full_count_again",  {126'b0, count}, 128'd2);
    exp_q.push_back(128'hC);
    we = 1'b0;
    re = 1'b0;
    @(negedge clk);
    chk("full_wack_low", {127'b0, wack}, 128'd0);
    chk("full_rack_low", {127'b0, rack}, 128'd0);
    read_rec();
    read_rec();
    chk("full_drained", {126'b0, count}, 128'd0);

    // Wrap-around: 7 records, reading whenever the buffer fills.
    for (int i = 0; i < 7; i++) begin
      write_rec(128'h5000 + 128'(i));
      exp_q.push_back(128'h5000 + 128'(i));
      chk("wrap_count_bound", {127'b0, (count > 3'(DEPTH))}, 128'd0);
      if (count == 2) read_rec();
    end
    while (exp_q.size() > 0) read_rec();
    chk("wrap_count0", {126'b0, count}, 128'd0);
    chk("wrap_avail0", {127'b0, avail}, 128'd0);

    // Simultaneous read and write with count=1.
    write_rec(128'h7777);
    @(negedge clk);
    we  = 1'b1;
    din = 128'h8888;
    re  = 1'b1;
    @(negedge clk);
    chk("sim_wack",  {127'b0, wack},  128'd1);
    chk("sim_rack",  {127'b0, rack},  128'd1);
    chk("sim_dout",  dout,            128'h7777);
    chk("sim_count", {126'b0, count}, 128'd1);
    we = 1'b0;
    re = 1'b0;
    @(negedge clk);
    exp_q.push_back(128'h8888);
    read_rec();
    chk("sim_count0", {126'b0, count}, 128'd0);

`ifdef PIPE_BUF_FLUSH_EN
    // Flush together with a write into a full buffer.
    write_rec(128'h1);
    write_rec(128'h2);
    chk("flush_pre_count", {126'b0, count}, 128'd2);
    @(negedge clk);
    flush = 1'b1;
    we    = 1'b1;
    din   = 128'hF00D;
    @(negedge clk);
    chk("flush_count", {126'b0, count}, 128'd0);
    chk("flush_avail", {127'b0, avail}, 128'd0);
    chk("flush_wack",  {127'b0, wack},  128'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_next_wack",  {127'b0, wack},  128'd1);
    chk("flush_next_count", {126'b0, count}, 128'd1);
    we = 1'b0;
    @(negedge clk);
    exp_q.push_back(128'hF00D);
    read_rec();
`endif

    // Reset mid-write: acks and occupancy drop without a clock edge.
    @(negedge clk);
    we  = 1'b1;
    din = 128'h9999;
    @(negedge clk);
    chk("rstmid_wack_hi", {127'b0, wack},  128'd1);
    chk("rstmid_count1",  {126'b0, count}, 128'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_wack",  {127'b0, wack},  128'd0);
    chk("rstmid_rack",  {127'b0, rack},  128'd0);
    chk("rstmid_avail", {127'b0, avail}, 128'd0);
    chk("rstmid_count", {126'b0, count}, 128'd0);
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
